// File: rtl/pe_os_acc.sv
// Output-stationary systolic PE: forwards north/west operands, accumulates
// gated MACs per tile with optional saturation, then shifts the result out a chain.
module pe_os_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [CNT_WIDTH-1:0]  k_len,
  input  logic [DATA_WIDTH-1:0] north_data,
  input  logic                  north_valid,
  input  logic [DATA_WIDTH-1:0] west_data,
  input  logic                  west_valid,
  output logic [DATA_WIDTH-1:0] south_data,
  output logic                  south_valid,
  output logic [DATA_WIDTH-1:0] east_data,
  output logic                  east_valid,
  input  logic                  drain_shift,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_in_valid,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_out_valid,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int PW = 2 * DATA_WIDTH;

  logic [1:0]                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]        mac_cnt;
  logic [CNT_WIDTH-1:0]        k_len_q;
  logic [CNT_WIDTH-1:0]        cnt_nxt;
  logic                        smode_q;

  logic signed [PW-1:0]        north_s;
  logic signed [PW-1:0]        west_s;
  logic signed [PW-1:0]        prod_s;
  logic [PW-1:0]               north_u;
  logic [PW-1:0]               west_u;
  logic [PW-1:0]               prod_u;
  logic signed [ACC_WIDTH-1:0] prod_se;
  logic [ACC_WIDTH-1:0]        prod_ze;
  logic [ACC_WIDTH-1:0]        prod_ext;
  logic [ACC_WIDTH:0]          add_res;
  logic                        mac_fire;

  // Returns {overflow, result}; overflow is signed range or unsigned carry-out.
  function automatic logic [ACC_WIDTH:0] mac_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [ACC_WIDTH-1:0] p,
    input logic                 smode
  );
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] res;
    logic                 ovf;
    sum = {1'b0, a} + {1'b0, p};
    if (smode)
      ovf = (a[ACC_WIDTH-1] == p[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    else
      ovf = sum[ACC_WIDTH];
    res = sum[ACC_WIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      if (!smode)
        res = '1;
      else if (a[ACC_WIDTH-1])
        res = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        res = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return {ovf, res};
  endfunction

  assign north_s  = PW'($signed(north_data));
  assign west_s   = PW'($signed(west_data));
  assign prod_s   = north_s * west_s;
  assign north_u  = PW'(north_data);
  assign west_u   = PW'(west_data);
  assign prod_u   = north_u * west_u;
  assign prod_se  = ACC_WIDTH'(prod_s);
  assign prod_ze  = ACC_WIDTH'(prod_u);
  assign prod_ext = smode_q ? prod_se : prod_ze;
  assign add_res  = mac_add(acc, prod_ext, smode_q);
  assign cnt_nxt  = mac_cnt + CNT_WIDTH'(1);
  assign mac_fire = (state == S_ACC) && north_valid && west_valid;
  assign done     = (state == S_DONE);

  // Operand forwarding stage: unconditional one-cycle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      south_data  <= '0;
      south_valid <= 1'b0;
      east_data   <= '0;
      east_valid  <= 1'b0;
    end else begin
      south_data  <= north_data;
      south_valid <= north_valid;
      east_data   <= west_data;
      east_valid  <= west_valid;
    end
  end

  // Tile control, accumulator and result chain stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      acc            <= '0;
      mac_cnt        <= '0;
      k_len_q        <= '0;
      smode_q        <= 1'b0;
      overflow       <= 1'b0;
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
    end else if (start) begin
      acc            <= '0;
      mac_cnt        <= '0;
      k_len_q        <= k_len;
      smode_q        <= signed_mode;
      overflow       <= 1'b0;
      psum_out_valid <= 1'b0;
      state          <= (k_len == '0) ? S_DONE : S_ACC;
    end else begin
      case (state)
        S_ACC: begin
          if (mac_fire) begin
            acc      <= add_res[ACC_WIDTH-1:0];
            overflow <= overflow | add_res[ACC_WIDTH];
            mac_cnt  <= cnt_nxt;
            if (cnt_nxt == k_len_q)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (drain_shift) begin
            psum_out       <= acc;
            psum_out_valid <= 1'b1;
            state          <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_shift) begin
            psum_out       <= psum_in;
            psum_out_valid <= psum_in_valid;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_os_acc.sv
// Directed bench for pe_os_acc: a default 32-bit PE plus 16-bit saturating and
// wrapping PEs driven by the same stimulus.
module tb_pe_os_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] k_len = '0;
  logic [7:0]  north_data = '0;
  logic        north_valid = 1'b0;
  logic [7:0]  west_data = '0;
  logic        west_valid = 1'b0;
  logic        drain_shift = 1'b0;
  logic [31:0] psum_in = '0;
  logic        psum_in_valid = 1'b0;
  logic [15:0] psum_in16;

  logic [7:0]  south_data, east_data;
  logic        south_valid, east_valid;
  logic [31:0] psum_out;
  logic        psum_out_valid, done, overflow;

  logic [7:0]  s_south_data, s_east_data, w_south_data, w_east_data;
  logic        s_south_valid, s_east_valid, w_south_valid, w_east_valid;
  logic [15:0] s_psum_out, w_psum_out;
  logic        s_psum_out_valid, s_done, s_overflow;
  logic        w_psum_out_valid, w_done, w_overflow;

  int vectors = 0;
  int miscompares = 0;

  assign psum_in16 = psum_in[15:0];

  always #5 clk = ~clk;

  pe_os_acc u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .k_len(k_len),
    .north_data(north_data), .north_valid(north_valid),
    .west_data(west_data), .west_valid(west_valid),
    .south_data(south_data), .south_valid(south_valid),
    .east_data(east_data), .east_valid(east_valid),
    .drain_shift(drain_shift), .psum_in(psum_in), .psum_in_valid(psum_in_valid),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid),
    .done(done), .overflow(overflow)
  );

  pe_os_acc #(.ACC_WIDTH(16), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .k_len(k_len),
    .north_data(north_data), .north_valid(north_valid),
    .west_data(west_data), .west_valid(west_valid),
    .south_data(s_south_data), .south_valid(s_south_valid),
    .east_data(s_east_data), .east_valid(s_east_valid),
    .drain_shift(drain_shift), .psum_in(psum_in16), .psum_in_valid(psum_in_valid),
    .psum_out(s_psum_out), .psum_out_valid(s_psum_out_valid),
    .done(s_done), .overflow(s_overflow)
  );

  pe_os_acc #(.ACC_WIDTH(16), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .k_len(k_len),
    .north_data(north_data), .north_valid(north_valid),
    .west_data(west_data), .west_valid(west_valid),
    .south_data(w_south_data), .south_valid(w_south_valid),
    .east_data(w_east_data), .east_valid(w_east_valid),
    .drain_shift(drain_shift), .psum_in(psum_in16), .psum_in_valid(psum_in_valid),
    .psum_out(w_psum_out), .psum_out_valid(w_psum_out_valid),
    .done(w_done), .overflow(w_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [7:0] n, input logic [7:0] w);
    north_data = n; west_data = w; north_valid = 1'b1; west_valid = 1'b1;
    tick();
  endtask

  task automatic idle_ops();
    north_valid = 1'b0; west_valid = 1'b0;
  endtask

  task automatic begin_tile(input logic [15:0] k, input logic sm);
    k_len = k; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (south_data !== 8'd0 || east_data !== 8'd0) begin miscompares++; $display("FAIL reset_fwd_data: south %0d east %0d want 0", south_data, east_data); end
    vectors++; if (south_valid !== 1'b0 || east_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fwd_valid: %b%b want 00", south_valid, east_valid); end
    vectors++; if (psum_out !== 32'd0 || psum_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_psum: %0d v%b want 0 v0", psum_out, psum_out_valid); end
    vectors++; if (done !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_flags: done %b ovf %b want 0 0", done, overflow); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    begin_tile(16'd3, 1'b0);
    pair(8'd3, 8'd4);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL unsigned_done_early1: got %b want 0", done); end
    pair(8'd0, 8'd9);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL unsigned_done_early2: got %b want 0", done); end
    pair(8'd255, 8'd255);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL unsigned_done: got %b want 1", done); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL unsigned_ovf: got %b want 0", overflow); end
    pair(8'd1, 8'd1);
    idle_ops();
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    vectors++; if (psum_out !== 32'd65037 || psum_out_valid !== 1'b1) begin miscompares++; $display("FAIL unsigned_acc: got %0d v%b want 65037 v1", psum_out, psum_out_valid); end
  endtask

  task automatic test_signed();
    begin_tile(16'd2, 1'b1);
    pair(8'hFE, 8'h07);
    pair(8'hFF, 8'hFF);
    idle_ops();
    vectors++; if (done !== 1'b1 || overflow !== 1'b0) begin miscompares++; $display("FAIL signed_flags: done %b ovf %b want 1 0", done, overflow); end
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    vectors++; if (psum_out !== 32'hFFFF_FFF3) begin miscompares++; $display("FAIL signed_acc: got %h want fffffff3", psum_out); end
  endtask

  task automatic test_gating();
    logic       st_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       nv_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] nd_t [5] = '{8'd5, 8'd9, 8'd7, 8'd2, 8'd1};
    logic       wv_t [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] wd_t [5] = '{8'd5, 8'd8, 8'd0, 8'd2, 8'd1};
    k_len = 16'd2; signed_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = st_t[i];
      north_data = nd_t[i]; north_valid = nv_t[i];
      west_data = wd_t[i]; west_valid = wv_t[i];
      tick();
      vectors++; if (south_data !== nd_t[i] || south_valid !== nv_t[i]) begin miscompares++; $display("FAIL gating_south[%0d]: got %0d v%b want %0d v%b", i, south_data, south_valid, nd_t[i], nv_t[i]); end
      vectors++; if (east_data !== wd_t[i] || east_valid !== wv_t[i]) begin miscompares++; $display("FAIL gating_east[%0d]: got %0d v%b want %0d v%b", i, east_data, east_valid, wd_t[i], wv_t[i]); end
      if (i == 3) begin
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL gating_done_early: got %b want 0", done); end
      end
    end
    start = 1'b0;
    idle_ops();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL gating_done: got %b want 1", done); end
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    vectors++; if (psum_out !== 32'd5) begin miscompares++; $display("FAIL gating_acc: got %0d want 5", psum_out); end
  endtask

  task automatic test_saturation();
    begin_tile(16'd4, 1'b1);
    for (int i = 0; i < 4; i++) pair(8'd127, 8'd127);
    idle_ops();
    vectors++; if (s_overflow !== 1'b1 || w_overflow !== 1'b1) begin miscompares++; $display("FAIL sat_ovf16: sat %b wrap %b want 1 1", s_overflow, w_overflow); end
    vectors++; if (overflow !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL sat_ovf32: ovf %b done %b want 0 1", overflow, done); end
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    vectors++; if (s_psum_out !== 16'h7FFF) begin miscompares++; $display("FAIL sat_clamp: got %h want 7fff", s_psum_out); end
    vectors++; if (w_psum_out !== 16'hFC04) begin miscompares++; $display("FAIL sat_wrap: got %h want fc04", w_psum_out); end
    vectors++; if (psum_out !== 32'd64516) begin miscompares++; $display("FAIL sat_wide: got %0d want 64516", psum_out); end
  endtask

  task automatic test_drain();
    begin_tile(16'd1, 1'b0);
    pair(8'd6, 8'd7);
    idle_ops();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL drain_done: got %b want 1", done); end
    drain_shift = 1'b1; psum_in = 32'd100; psum_in_valid = 1'b0;
    tick();
    vectors++; if (psum_out !== 32'd42 || psum_out_valid !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL drain_first: got %0d v%b done %b want 42 v1 done 0", psum_out, psum_out_valid, done); end
    psum_in = 32'd7; psum_in_valid = 1'b1;
    tick();
    vectors++; if (psum_out !== 32'd7 || psum_out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_second: got %0d v%b want 7 v1", psum_out, psum_out_valid); end
    psum_in = 32'd9;
    tick();
    vectors++; if (psum_out !== 32'd9 || psum_out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_third: got %0d v%b want 9 v1", psum_out, psum_out_valid); end
    drain_shift = 1'b0; psum_in = 32'd55;
    tick();
    vectors++; if (psum_out !== 32'd9 || psum_out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_hold: got %0d v%b want 9 v1", psum_out, psum_out_valid); end
    psum_in_valid = 1'b0;
    begin_tile(16'd2, 1'b0);
    vectors++; if (psum_out_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL drain_restart: v%b done %b want v0 done 0", psum_out_valid, done); end
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    vectors++; if (psum_out_valid !== 1'b0 || psum_out !== 32'd9) begin miscompares++; $display("FAIL drain_ignored_in_acc: got %0d v%b want 9 v0", psum_out, psum_out_valid); end
  endtask

  task automatic test_async_reset();
    begin_tile(16'd3, 1'b0);
    pair(8'd3, 8'd4);
    #2 rst = 1'b1;
    #1;
    vectors++; if (south_data !== 8'd0 || east_data !== 8'd0 || south_valid !== 1'b0 || east_valid !== 1'b0) begin miscompares++; $display("FAIL async_fwd: south %0d east %0d v%b%b want all 0", south_data, east_data, south_valid, east_valid); end
    vectors++; if (psum_out !== 32'd0 || psum_out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL async_state: psum %0d v%b done %b ovf %b want all 0", psum_out, psum_out_valid, done, overflow); end
    idle_ops();
    #2 rst = 1'b0;
    k_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL async_klen0_done: got %b want 1", done); end
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    vectors++; if (psum_out !== 32'd0 || psum_out_valid !== 1'b1) begin miscompares++; $display("FAIL async_discarded: got %0d v%b want 0 v1", psum_out, psum_out_valid); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_gating();
    test_saturation();
    test_drain();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
